// File: rtl/fifo_serial_tx_pkg.sv
// rtl/fifo_serial_tx_pkg.sv - state encoding and line levels for the FIFO serial transmitter
// Contents: FSM state codes, serial line level constants, busy decode helper.
package fifo_serial_tx_pkg;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] REQ     = 3'd1;
    localparam logic [2:0] WAIT    = 3'd2;
    localparam logic [2:0] BACKOFF = 3'd3;
    localparam logic [2:0] START   = 3'd4;
    localparam logic [2:0] DATA    = 3'd5;
    localparam logic [2:0] PARITY  = 3'd6;
    localparam logic [2:0] STOP    = 3'd7;

    localparam logic TX_IDLE   = 1'b1;
    localparam logic START_BIT = 1'b0;

    // Busy covers the whole fetch-and-send path; only idling and the
    // empty-FIFO backoff count as not busy.
    function automatic logic is_busy(input logic [2:0] s);
        return !(s == IDLE || s == BACKOFF);
    endfunction

endpackage

// File: rtl/tx_bit_timer.sv
// rtl/tx_bit_timer.sv - serial bit-period divider
// Ports:
//   clock    in  single clock, posedge
//   reset    in  synchronous, active-high
//   restart  in  zero the divider so the next cycle is the first of a bit
//   bit_done out high on the last cycle of each CLK_DIV-cycle bit period
module tx_bit_timer #(
    parameter int CLK_DIV = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic restart,
    output logic bit_done
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clock) begin
        if (reset || restart) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign bit_done = (cnt == LAST);

endmodule

// File: rtl/fifo_serial_tx.sv
// rtl/fifo_serial_tx.sv - pops words from the FIFO and sends each as an async serial frame
// Frame: start(0), DATA_W data bits LSB first, [even parity], stop(1); CLK_DIV cycles per bit.
// Build option: FIFO_SERIAL_TX_PARITY_EN adds the even parity bit after the data bits.
// Ports:
//   clock      in   single clock, posedge
//   reset      in   synchronous, active-high
//   enable     in   1 = keep draining the FIFO; 0 = stop after the current frame
//   fifo_read  out  one-cycle read strobe, only in REQ
//   fifo_data  in   FIFO dataout, valid with fifo_val
//   fifo_val   in   FIFO returned a word on the cycle after fifo_read
//   tx         out  registered serial line, idle high
//   busy       out  high from REQ through the last stop-bit cycle
module fifo_serial_tx
    import fifo_serial_tx_pkg::*;
#(
    parameter int DATA_W       = 10,
    parameter int CLK_DIV      = 4,
    parameter int RETRY_CYCLES = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    output logic              fifo_read,
    input  logic [DATA_W-1:0] fifo_data,
    input  logic              fifo_val,
    output logic              tx,
    output logic              busy
);

    localparam int BW = $clog2(DATA_W + 1);
    localparam int RW = $clog2(RETRY_CYCLES + 1);
    localparam logic [BW-1:0] LAST_BIT   = BW'(DATA_W - 1);
    localparam logic [RW-1:0] LAST_RETRY = RW'(RETRY_CYCLES - 1);

    logic [2:0]        state;
    logic [DATA_W-1:0] shift;
    logic [DATA_W-1:0] shift_nx;
    logic [BW-1:0]     bit_cnt;
    logic [RW-1:0]     retry_cnt;
    logic              bit_done;
    logic              restart;
`ifdef FIFO_SERIAL_TX_PARITY_EN
    logic              par;
`endif

    // The divider is zeroed on the edge that enters START so every bit of
    // the frame lasts exactly CLK_DIV cycles from the first start-bit cycle.
    assign restart  = (state == WAIT) && fifo_val;
    assign shift_nx = shift >> 1;

    assign fifo_read = (state == REQ);
    assign busy      = is_busy(state);

    tx_bit_timer #(.CLK_DIV(CLK_DIV)) u_timer (
        .clock    (clock),
        .reset    (reset),
        .restart  (restart),
        .bit_done (bit_done)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            tx        <= TX_IDLE;
            shift     <= '0;
            bit_cnt   <= '0;
            retry_cnt <= '0;
`ifdef FIFO_SERIAL_TX_PARITY_EN
            par       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (enable) state <= REQ;
                end
                REQ: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (fifo_val) begin
                        shift <= fifo_data;
                        tx    <= START_BIT;
                        state <= START;
`ifdef FIFO_SERIAL_TX_PARITY_EN
                        // Parity taken at latch time; the shift register is consumed while sending.
                        par   <= ^fifo_data;
`endif
                    end else begin
                        retry_cnt <= '0;
                        state     <= BACKOFF;
                    end
                end
                BACKOFF: begin
                    if (retry_cnt == LAST_RETRY) begin
                        state <= IDLE;
                    end else begin
                        retry_cnt <= retry_cnt + RW'(1);
                    end
                end
                START: begin
                    if (bit_done) begin
                        tx      <= shift[0];
                        bit_cnt <= '0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        if (bit_cnt == LAST_BIT) begin
`ifdef FIFO_SERIAL_TX_PARITY_EN
                            tx    <= par;
                            state <= PARITY;
`else
                            tx    <= TX_IDLE;
                            state <= STOP;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + BW'(1);
                            shift   <= shift_nx;
                            tx      <= shift_nx[0];
                        end
                    end
                end
`ifdef FIFO_SERIAL_TX_PARITY_EN
                PARITY: begin
                    if (bit_done) begin
                        tx    <= TX_IDLE;
                        state <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (bit_done) state <= enable ? REQ : IDLE;
                end
                default: begin
                    tx    <= TX_IDLE;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_serial_tx.sv
// tb/tb_fifo_serial_tx.sv - directed self-checking bench for fifo_serial_tx
module tb_fifo_serial_tx;

    localparam int DATA_W       = 10;
    localparam int CLK_DIV      = 4;
    localparam int RETRY_CYCLES = 8;
`ifdef FIFO_SERIAL_TX_PARITY_EN
    localparam int NBITS = DATA_W + 3;
`else
    localparam int NBITS = DATA_W + 2;
`endif
    localparam int FL = NBITS * CLK_DIV;

    logic              clock = 1'b0;
    logic              reset;
    logic              enable;
    logic              fifo_read;
    logic [DATA_W-1:0] fifo_data = '0;
    logic              fifo_val = 1'b0;
    logic              tx;
    logic              busy;

    logic [DATA_W-1:0] q[$];
    int                reads_cnt = 0;
    int                checks = 0;
    int                failures = 0;

    fifo_serial_tx #(
        .DATA_W       (DATA_W),
        .CLK_DIV      (CLK_DIV),
        .RETRY_CYCLES (RETRY_CYCLES)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .fifo_read (fifo_read),
        .fifo_data (fifo_data),
        .fifo_val  (fifo_val),
        .tx        (tx),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    // FIFO read side: a read sampled at edge N answers during cycle N+1.
    always @(posedge clock) begin
        if (fifo_read && q.size() > 0) begin
            fifo_data <= q.pop_front();
            fifo_val  <= 1'b1;
        end else begin
            fifo_data <= '1;
            fifo_val  <= 1'b0;
        end
        if (fifo_read) reads_cnt <= reads_cnt + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic frame_bit(input logic [DATA_W-1:0] w, input int k);
        if (k == 0) return 1'b0;
        if (k <= DATA_W) return w[k-1];
`ifdef FIFO_SERIAL_TX_PARITY_EN
        if (k == DATA_W + 1) return ^w;
`endif
        return 1'b1;
    endfunction

    task automatic wait_start(input int limit, output int waited);
        waited = 0;
        while (tx !== 1'b0 && waited < limit) begin
            @(negedge clock);
            waited++;
        end
    endtask

    // Called on the negedge of the first start-bit cycle; returns on the
    // negedge of the first cycle after the stop bit.
    task automatic check_frame(input string tag, input logic [DATA_W-1:0] w, input int drop_at,
                               output logic [DATA_W-1:0] got, output logic got_after);
        int bad;
        bad = 0;
        got = '0;
        got_after = 1'bx;
        for (int i = 0; i < FL; i++) begin
            int k;
            k = i / CLK_DIV;
            if (tx !== frame_bit(w, k)) bad++;
            if (i % CLK_DIV == CLK_DIV / 2) begin
                if (k >= 1 && k <= DATA_W) got[k-1] = tx;
                if (k == DATA_W + 1) got_after = tx;
            end
            if (i == drop_at) enable = 1'b0;
            @(negedge clock);
        end
        chk({tag, "_bad_cycles"}, bad, 0);
        chk({tag, "_word"}, {22'd0, got}, {22'd0, w});
    endtask

    initial begin
        int waited;
        int r0;
        int bad;
        logic [DATA_W-1:0] got;
        logic got_after;

        // 1: reset for two cycles
        reset = 1'b1;
        enable = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clock);
            chk("rst_tx", {31'd0, tx}, 1);
            chk("rst_busy", {31'd0, busy}, 0);
            chk("rst_read", {31'd0, fifo_read}, 0);
        end

        // 2: single word 10'h2A5
        reset = 1'b0;
        q.push_back(10'h2A5);
        r0 = reads_cnt;
        enable = 1'b1;
        wait_start(40, waited);
        chk("w2a5_latency", waited, 3);
        check_frame("w2a5", 10'h2A5, -1, got, got_after);
        chk("w2a5_after_data", {31'd0, got_after}, 1);
        chk("w2a5_one_read", reads_cnt - r0, 1);

        // 3: empty FIFO, retry every 11 cycles; now in REQ of the next attempt
        bad = 0;
        for (int c = 0; c < 33; c++) begin
            if (fifo_read !== ((c % 11) == 0)) bad++;
            if (busy !== ((c % 11) < 2)) bad++;
            if (tx !== 1'b1) bad++;
            @(negedge clock);
        end
        chk("empty_retry_bad", bad, 0);
        chk("empty_retry_read", {31'd0, fifo_read}, 1);
        enable = 1'b0;
        repeat (12) @(negedge clock);
        chk("empty_idle_busy", {31'd0, busy}, 0);

        // 4: three back-to-back frames
        q.push_back(10'h011);
        q.push_back(10'h022);
        q.push_back(10'h033);
        r0 = reads_cnt;
        enable = 1'b1;
        wait_start(40, waited);
        chk("b2b_latency0", waited, 3);
        check_frame("b2b_11", 10'h011, -1, got, got_after);
        wait_start(40, waited);
        chk("b2b_gap1", waited, 2);
        check_frame("b2b_22", 10'h022, -1, got, got_after);
        wait_start(40, waited);
        chk("b2b_gap2", waited, 2);
        check_frame("b2b_33", 10'h033, -1, got, got_after);
        enable = 1'b0;
        repeat (12) @(negedge clock);
        chk("b2b_reads", reads_cnt - r0, 4);
        chk("b2b_fifo_empty", q.size(), 0);

        // 5a: enable dropped mid-data of word 44
        q.push_back(10'h044);
        r0 = reads_cnt;
        enable = 1'b1;
        wait_start(40, waited);
        chk("drop_latency", waited, 3);
        check_frame("drop_44", 10'h044, 20, got, got_after);
        repeat (15) @(negedge clock);
        chk("drop_reads", reads_cnt - r0, 1);
        chk("drop_busy", {31'd0, busy}, 0);
        chk("drop_tx", {31'd0, tx}, 1);

        // 5b: reset mid-frame of word 44, word 55 must stay in the FIFO
        q.push_back(10'h044);
        q.push_back(10'h055);
        r0 = reads_cnt;
        enable = 1'b1;
        wait_start(40, waited);
        chk("rst_mid_latency", waited, 3);
        repeat (20) @(negedge clock);
        chk("rst_mid_bit4", {31'd0, tx}, 0);
        reset = 1'b1;
        enable = 1'b0;
        @(negedge clock);
        chk("rst_mid_tx", {31'd0, tx}, 1);
        chk("rst_mid_busy", {31'd0, busy}, 0);
        reset = 1'b0;
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            if (tx !== 1'b1 || fifo_read !== 1'b0) bad++;
            @(negedge clock);
        end
        chk("rst_mid_quiet", bad, 0);
        chk("rst_mid_reads", reads_cnt - r0, 1);
        chk("rst_mid_left", q.size(), 1);
        if (q.size() > 0) chk("rst_mid_55", {22'd0, q[0]}, 32'h055);
        q.delete();

`ifdef FIFO_SERIAL_TX_PARITY_EN
        // 6: parity build, word 10'h007 has odd weight -> parity bit 1
        q.push_back(10'h007);
        enable = 1'b1;
        wait_start(40, waited);
        chk("par_latency", waited, 3);
        check_frame("par_007", 10'h007, -1, got, got_after);
        chk("par_bit", {31'd0, got_after}, 1);
        enable = 1'b0;
        repeat (12) @(negedge clock);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
